// File: rtl/seven_seg_scan_n.sv
// Multiplexed seven-segment scanner for NUM_DIGITS hex digits with decimal
// points, per-digit blanking, leading-zero suppression, 16-level PWM
// brightness and frame-synchronous input capture. All outputs registered.
module seven_seg_scan_n #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] val,
  input  logic [NUM_DIGITS-1:0]   dot,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzs_en,
  input  logic [3:0]              bright,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [PRE_W-1:0]        pre;
  logic [IDX_W-1:0]        idx;
  logic                    eof;

  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_dot;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic                    sh_lzs;
  logic [3:0]              sh_bright;

  logic [NUM_DIGITS-1:0]   supp;
  logic                    seen;
  logic [3:0]              cur_val;
  logic                    cur_dot;
  logic                    cur_en;
  logic                    cur_supp;
  logic                    pwm_on;
  logic [NUM_DIGITS-1:0]   an_on;
  logic [6:0]              seg_on;
  logic                    dp_on;

  // Hex to segment pattern, active-high, bit order g..a
  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    case (h)
      4'h0:    hex_decode = 7'b0111111;
      4'h1:    hex_decode = 7'b0000110;
      4'h2:    hex_decode = 7'b1011011;
      4'h3:    hex_decode = 7'b1001111;
      4'h4:    hex_decode = 7'b1100110;
      4'h5:    hex_decode = 7'b1101101;
      4'h6:    hex_decode = 7'b1111101;
      4'h7:    hex_decode = 7'b0000111;
      4'h8:    hex_decode = 7'b1111111;
      4'h9:    hex_decode = 7'b1101111;
      4'hA:    hex_decode = 7'b1110111;
      4'hB:    hex_decode = 7'b1111100;
      4'hC:    hex_decode = 7'b0111001;
      4'hD:    hex_decode = 7'b1011110;
      4'hE:    hex_decode = 7'b1111001;
      default: hex_decode = 7'b1110001;
    endcase
  endfunction

  assign eof = (pre == PRE_LAST) && (idx == IDX_LAST);

  // Slot prescaler and digit index; idx advances at the end of each slot
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Shadow copy of the inputs, refreshed only at end of frame so a frame never tears
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_val    <= '0;
      sh_dot    <= '0;
      sh_en     <= '0;
      sh_lzs    <= 1'b0;
      sh_bright <= '0;
    end else if (eof) begin
      sh_val    <= val;
      sh_dot    <= dot;
      sh_en     <= digit_en;
      sh_lzs    <= lzs_en;
      sh_bright <= bright;
    end
  end

  // Leading-zero mask: walk down from the top digit until a displayed nonzero digit
  always_comb begin
    supp = '0;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (!seen && !(sh_en[i] && (sh_val[4*i +: 4] != 4'd0)))
        supp[i] = 1'b1;
      if (sh_en[i] && (sh_val[4*i +: 4] != 4'd0))
        seen = 1'b1;
    end
    if (!sh_lzs)
      supp = '0;
  end

  // Select the digit currently being scanned and form active-high drive levels
  always_comb begin
    cur_val  = '0;
    cur_dot  = 1'b0;
    cur_en   = 1'b0;
    cur_supp = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_val  = sh_val[4*i +: 4];
        cur_dot  = sh_dot[i];
        cur_en   = sh_en[i];
        cur_supp = supp[i];
      end
    end
    pwm_on = (sh_bright == 4'hF) || (pre[3:0] < sh_bright);
    an_on  = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      an_on[i] = (idx == IDX_W'(i)) && cur_en && pwm_on;
    seg_on = (cur_en && !cur_supp) ? hex_decode(cur_val) : 7'b0000000;
    dp_on  = cur_en && cur_dot;
  end

  // Registered pin drivers with board polarity applied
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= {NUM_DIGITS{POL}};
      seg        <= {7{POL}};
      dp         <= POL;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_on ^ {NUM_DIGITS{POL}};
      seg        <= seg_on ^ {7{POL}};
      dp         <= dp_on ^ POL;
      frame_tick <= eof;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Directed bench for seven_seg_scan_n with 4 digits, 32-cycle slots, active-low pins.
module tb_seven_seg_scan_n;

  localparam logic [6:0] S_0     = 7'b1000000;
  localparam logic [6:0] S_1     = 7'b1111001;
  localparam logic [6:0] S_2     = 7'b0100100;
  localparam logic [6:0] S_3     = 7'b0110000;
  localparam logic [6:0] S_5     = 7'b0010010;
  localparam logic [6:0] S_A     = 7'b0001000;
  localparam logic [6:0] S_B     = 7'b0000011;
  localparam logic [6:0] S_C     = 7'b1000110;
  localparam logic [6:0] S_D     = 7'b0100001;
  localparam logic [6:0] S_BLANK = 7'b1111111;

  logic        clk;
  logic        rst;
  logic [15:0] val;
  logic [3:0]  dot;
  logic [3:0]  digit_en;
  logic        lzs_en;
  logic [3:0]  bright;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int checks;
  int errors;

  logic [15:0] pend_val;
  logic [3:0]  pend_dot;
  logic [3:0]  pend_en;
  logic        pend_lzs;
  logic [3:0]  pend_bright;

  seven_seg_scan_n #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(32),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .val(val),
    .dot(dot),
    .digit_en(digit_en),
    .lzs_en(lzs_en),
    .bright(bright),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_tick(frame_tick)
  );

  // 100 MHz board clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic [15:0] v, input logic [3:0] d,
                                input logic [3:0] e, input logic l, input logic [3:0] b);
    val      = v;
    dot      = d;
    digit_en = e;
    lzs_en   = l;
    bright   = b;
  endtask

  task automatic set_pending(input logic [15:0] v, input logic [3:0] d,
                             input logic [3:0] e, input logic l, input logic [3:0] b);
    pend_val    = v;
    pend_dot    = d;
    pend_en     = e;
    pend_lzs    = l;
    pend_bright = b;
  endtask

  task automatic check_output(input string tag, input int cyc,
                              input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  // One full 128-cycle frame; slot s shows segs[s], dp level dpx[s], anode gated by anm/duty.
  task automatic check_frame(input string tag,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] dpx, input logic [3:0] anm,
                             input int duty, input int chg_j);
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int slot;
    int p;
    for (int j = 0; j < 128; j++) begin
      @(negedge clk);
      slot   = j / 32;
      p      = j % 32;
      exp_an = 4'hF;
      if (anm[slot] && (duty >= 16 || (p % 16) < duty))
        exp_an[slot] = 1'b0;
      case (slot)
        0:       exp_seg = s0;
        1:       exp_seg = s1;
        2:       exp_seg = s2;
        default: exp_seg = s3;
      endcase
      check_output({tag, " an"},  j, {4'b0, an},  {4'b0, exp_an});
      check_output({tag, " seg"}, j, {1'b0, seg}, {1'b0, exp_seg});
      check_output({tag, " dp"},  j, {7'b0, dp},  {7'b0, dpx[slot]});
      check_output({tag, " frame_tick"}, j, {7'b0, frame_tick}, {7'b0, (j == 127)});
      if (j == chg_j)
        apply_stimulus(pend_val, pend_dot, pend_en, pend_lzs, pend_bright);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    set_pending(16'h0000, 4'h0, 4'h0, 1'b0, 4'h0);

    rst = 1'b1;
    apply_stimulus(16'h0123, 4'b0101, 4'hF, 1'b0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("reset an",  i, {4'b0, an},  8'h0F);
      check_output("reset seg", i, {1'b0, seg}, 8'h7F);
      check_output("reset dp",  i, {7'b0, dp},  8'h01);
      check_output("reset frame_tick", i, {7'b0, frame_tick}, 8'h00);
    end
    rst = 1'b0;

    $display("[TB] first frame after reset is blank");
    check_frame("blank1", S_BLANK, S_BLANK, S_BLANK, S_BLANK, 4'hF, 4'h0, 16, -1);

    $display("[TB] second frame shows 0123 with dots on digits 0 and 2");
    set_pending(16'h0050, 4'h0, 4'hF, 1'b1, 4'hF);
    check_frame("hex0123", S_3, S_2, S_1, S_0, 4'b1010, 4'hF, 16, 10);

    $display("[TB] leading-zero suppression");
    set_pending(16'h0050, 4'h0, 4'b1110, 1'b1, 4'hF);
    check_frame("lzs", S_0, S_5, S_BLANK, S_BLANK, 4'hF, 4'hF, 16, 10);

    $display("[TB] digit 0 disabled");
    set_pending(16'h0050, 4'h0, 4'hF, 1'b0, 4'h4);
    check_frame("blank0", S_BLANK, S_5, S_BLANK, S_BLANK, 4'hF, 4'b1110, 16, 10);

    $display("[TB] brightness 4");
    set_pending(16'h0050, 4'h0, 4'hF, 1'b0, 4'h0);
    check_frame("bright4", S_0, S_5, S_0, S_0, 4'hF, 4'hF, 4, 10);

    $display("[TB] brightness 0");
    set_pending(16'h0123, 4'h0, 4'hF, 1'b0, 4'hF);
    check_frame("bright0", S_0, S_5, S_0, S_0, 4'hF, 4'hF, 0, 10);

    $display("[TB] val changes mid-frame at slot 1 pre 10");
    set_pending(16'hABCD, 4'h0, 4'hF, 1'b0, 4'hF);
    check_frame("tearfree", S_3, S_2, S_1, S_0, 4'hF, 4'hF, 16, 41);

    $display("[TB] new value appears from the next frame");
    check_frame("hexABCD", S_D, S_C, S_B, S_A, 4'hF, 4'hF, 16, -1);

    $display("[TB] reset during slot 2");
    for (int i = 0; i < 70; i++)
      @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("midreset an",  0, {4'b0, an},  8'h0F);
    check_output("midreset seg", 0, {1'b0, seg}, 8'h7F);
    check_output("midreset dp",  0, {7'b0, dp},  8'h01);
    check_output("midreset frame_tick", 0, {7'b0, frame_tick}, 8'h00);
    rst = 1'b0;
    check_frame("blank2", S_BLANK, S_BLANK, S_BLANK, S_BLANK, 4'hF, 4'h0, 16, -1);
    check_frame("recover", S_D, S_C, S_B, S_A, 4'hF, 4'hF, 16, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
